divmmc_spi: RTL and testbench

- SPI initiator for the DivMMC interface inside the zx48 core. It drives usdCk/usdCs/usdMosi and samples usdMiso.
- At top level these pins connect either to the virtual sd_card responder or to the physical SD pins.
- It decodes the Z80 I/O port writes and reads for the DivMMC card-select port (0xE7) and data port (0xEB).
- It runs one 8-bit SPI mode-0 exchange per data-port access and returns the received byte on the next data-port read.

---
 rtl/divmmc_pkg.sv | 17 +
 rtl/spi_shift8.sv | 102 ++++++++++
 rtl/divmmc_spi.sv | 71 +++++++
 tb/tb_divmmc_spi.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/divmmc_pkg.sv
// divmmc_pkg: shared constants and types for the DivMMC SPI initiator.
//   PORT_CS     - Z80 I/O port (low byte) that drives the card-select line
//   PORT_DATA   - Z80 I/O port (low byte) that starts an SPI byte exchange
//   IDLE_BYTE   - byte shifted out when an exchange is started by a read
//   spi_state_t - transfer state of the byte shifter
package divmmc_pkg;

  localparam logic [7:0] PORT_CS   = 8'hE7;
  localparam logic [7:0] PORT_DATA = 8'hEB;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: one 8-bit SPI mode-0 exchange, MSB first.
//   clock, reset - system clock, asynchronous active-high reset
//   start        - one-cycle request, honoured only while idle
//   tx_byte      - byte to shift out, captured on the accepting edge
//   miso         - serial data in, sampled on each SCK rising edge
//   sck, mosi    - serial clock (idles low) and data out (idles high)
//   busy         - exchange in progress
//   done         - one-cycle pulse on the clock that ends the exchange
//   rx_byte      - received byte, complete while done is high
module spi_shift8
  import divmmc_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  spi_state_t state_reg, state_next;
  logic [DW-1:0] div_reg;
  logic [3:0]    half_reg;
  logic [7:0]    tx_reg;
  logic [7:0]    rx_reg;
  logic          sck_reg;
  logic          mosi_reg;
  logic          tick;
  logic          last;

  // tick marks the final clock of a half-period; the 16th tick ends the byte.
  always_comb begin
    state_next = state_reg;
    tick       = (state_reg == ST_SHIFT) && (div_reg == DIV_LAST);
    last       = tick && (half_reg == 4'd15);
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_reg  <= '0;
      half_reg <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      sck_reg  <= 1'b0;
      mosi_reg <= 1'b1;
    end else if (state_reg == ST_IDLE) begin
      if (start) begin
        tx_reg   <= tx_byte;
        mosi_reg <= tx_byte[7];
        div_reg  <= '0;
        half_reg <= '0;
        sck_reg  <= 1'b0;
      end
    end else if (tick) begin
      div_reg  <= '0;
      half_reg <= half_reg + 4'd1;
      sck_reg  <= ~sck_reg;
      if (!sck_reg) begin
        // rising edge: sample the responder
        rx_reg <= {rx_reg[6:0], miso};
      end else if (half_reg == 4'd15) begin
        // eighth falling edge: line returns to its idle level
        mosi_reg <= 1'b1;
      end else begin
        // falling edge: present the next bit a full half-period before the rise
        tx_reg   <= {tx_reg[6:0], 1'b0};
        mosi_reg <= tx_reg[6];
      end
    end else begin
      div_reg <= div_reg + DW'(1);
    end
  end

  assign sck     = sck_reg;
  assign mosi    = mosi_reg;
  assign busy    = (state_reg == ST_SHIFT);
  assign done    = last;
  assign rx_byte = rx_reg;

endmodule

// File: rtl/divmmc_spi.sv
// divmmc_spi: DivMMC SPI initiator for the zx48 core.
//   clock, reset      - 56 MHz system clock, asynchronous active-high reset
//   a, iowr, iord     - Z80 I/O address low byte and single-cycle strobes
//   din               - CPU write data
//   dout              - last received byte (changes only when a byte completes)
//   busy              - exchange in progress
//   usdCk, usdCs      - SPI clock (idles low), card select (active low)
//   usdMosi, usdMiso  - SPI data out / in
// Port 0xE7 writes set the card select from din[0]; any access to 0xEB while
// idle starts an exchange (writes send din, reads send IDLE_TX).
module divmmc_spi
  import divmmc_pkg::*;
#(
  parameter int         CLKDIV  = 2,
  parameter logic [7:0] IDLE_TX = IDLE_BYTE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic       iowr,
  input  logic       iord,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       usdCk,
  output logic       usdCs,
  output logic       usdMosi,
  input  logic       usdMiso
);

  logic       cs_reg;
  logic [7:0] dout_reg;
  logic       start;
  logic [7:0] tx_byte;
  logic       done;
  logic [7:0] rx_byte;

  // Accesses to the data port while busy are dropped; a write beats a read.
  assign start   = (a == PORT_DATA) && (iowr || iord) && !busy;
  assign tx_byte = iowr ? din : IDLE_TX;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_reg   <= 1'b1;
      dout_reg <= 8'hFF;
    end else begin
      // Card select may change mid-exchange; the shifter keeps running.
      if ((a == PORT_CS) && iowr) cs_reg <= din[0];
      if (done) dout_reg <= rx_byte;
    end
  end

  spi_shift8 #(
    .CLKDIV (CLKDIV)
  ) u_shift (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .tx_byte (tx_byte),
    .miso    (usdMiso),
    .sck     (usdCk),
    .mosi    (usdMosi),
    .busy    (busy),
    .done    (done),
    .rx_byte (rx_byte)
  );

  assign dout  = dout_reg;
  assign usdCs = cs_reg;

endmodule

// File: tb/tb_divmmc_spi.sv
// tb_divmmc_spi: directed, table-driven bench for divmmc_spi (CLKDIV=2).
module tb_divmmc_spi;
  import divmmc_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'h00;
  logic       iowr = 1'b0;
  logic       iord = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy;
  logic       usdCk;
  logic       usdCs;
  logic       usdMosi;
  logic       usdMiso;

  logic       loop_en = 1'b1;
  logic [7:0] resp_sh = 8'hFF;
  logic [7:0] mosi_cap = 8'h00;
  int         rise_cnt = 0;

  int n_pass = 0;
  int n_total = 0;

  divmmc_spi #(.CLKDIV(2), .IDLE_TX(8'hFF)) dut (
    .clock   (clock),
    .reset   (reset),
    .a       (a),
    .iowr    (iowr),
    .iord    (iord),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .usdCk   (usdCk),
    .usdCs   (usdCs),
    .usdMosi (usdMosi),
    .usdMiso (usdMiso)
  );

  always #5 clock = ~clock;

  // responder: MSB presented before the first rise, next bit after each fall
  assign usdMiso = loop_en ? usdMosi : resp_sh[7];
  always @(negedge usdCk) resp_sh = {resp_sh[6:0], 1'b1};
  always @(posedge usdCk) begin
    mosi_cap = {mosi_cap[6:0], usdMosi};
    rise_cnt = rise_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic cs_write(input logic [7:0] d);
    a = PORT_CS; din = d; iowr = 1'b1;
    @(negedge clock);
    iowr = 1'b0;
  endtask

  // Starts an exchange at a negedge, counts busy cycles, optionally injects
  // an I/O write on busy cycle inj_at.
  task automatic run_xfer(input logic wr, input logic [7:0] d, input int inj_at,
                          input logic [7:0] inj_a, input logic [7:0] inj_d,
                          output int bcnt, output logic [7:0] rd_val, output logic cs_after);
    rise_cnt = 0; mosi_cap = 8'h00; cs_after = usdCs;
    a = PORT_DATA; din = d; iowr = wr; iord = ~wr;
    rd_val = dout;
    @(negedge clock);
    iowr = 1'b0; iord = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      if (bcnt == inj_at) begin a = inj_a; din = inj_d; iowr = 1'b1; end
      @(negedge clock);
      if (bcnt == inj_at) begin iowr = 1'b0; cs_after = usdCs; end
    end
  endtask

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] d;
    logic       loop;
    logic [7:0] miso_byte;
    logic [7:0] exp_mosi;
    logic [7:0] exp_dout;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bcnt;
    logic [7:0] rd_val;
    logic cs_after;

    vecs[0] = '{"wr_A5_loop", 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 8'hFF};
    vecs[1] = '{"rd_resp_3C", 1'b0, 8'h00, 1'b0, 8'h3C, 8'hFF, 8'h3C, 8'hA5};
    vecs[2] = '{"wr_00_resp_C3", 1'b1, 8'h00, 1'b0, 8'hC3, 8'h00, 8'hC3, 8'h3C};
    vecs[3] = '{"wr_FF_loop", 1'b1, 8'hFF, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hC3};
    vecs[4] = '{"rd_resp_81", 1'b0, 8'h00, 1'b0, 8'h81, 8'hFF, 8'h81, 8'hFF};

    // reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_usdCk", usdCk, 0);
    check("rst_usdCs", usdCs, 1);
    check("rst_usdMosi", usdMosi, 1);
    check("rst_dout", dout, 8'hFF);
    check("rst_busy", busy, 0);

    // reset pulse during clock 17 of an exchange aborts it
    cs_write(8'h00);
    check("cs_low", usdCs, 0);
    loop_en = 1'b1;
    a = PORT_DATA; din = 8'h5A; iowr = 1'b1;
    @(negedge clock);
    iowr = 1'b0;
    repeat (16) @(negedge clock);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_usdCk", usdCk, 0);
    check("abort_dout", dout, 8'hFF);
    check("abort_usdMosi", usdMosi, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_usdCs", usdCs, 1);

    // table of complete exchanges
    cs_write(8'h00);
    for (int i = 0; i < 5; i++) begin
      loop_en = vecs[i].loop;
      resp_sh = vecs[i].miso_byte;
      run_xfer(vecs[i].wr, vecs[i].d, 0, 8'h00, 8'h00, bcnt, rd_val, cs_after);
      check({vecs[i].name, "_busy_clks"}, bcnt, 32);
      check({vecs[i].name, "_rises"}, rise_cnt, 8);
      check({vecs[i].name, "_mosi"}, mosi_cap, vecs[i].exp_mosi);
      check({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
      if (!vecs[i].wr) check({vecs[i].name, "_read_val"}, rd_val, vecs[i].exp_rd);
      check({vecs[i].name, "_idle_mosi"}, {usdCk, usdMosi}, 2'b01);
    end

    // data write at clock 10 of a running exchange is dropped
    loop_en = 1'b1;
    run_xfer(1'b1, 8'h96, 10, PORT_DATA, 8'h55, bcnt, rd_val, cs_after);
    check("ign_busy_clks", bcnt, 32);
    check("ign_mosi", mosi_cap, 8'h96);
    check("ign_dout", dout, 8'h96);
    repeat (4) @(negedge clock);
    check("ign_no_restart", {busy, usdCk}, 2'b00);
    check("ign_dout_hold", dout, 8'h96);

    // card select raised mid-exchange, exchange completes
    run_xfer(1'b1, 8'h4B, 10, PORT_CS, 8'h01, bcnt, rd_val, cs_after);
    check("cs_mid_next_clk", cs_after, 1);
    check("cs_mid_busy_clks", bcnt, 32);
    check("cs_mid_rises", rise_cnt, 8);
    check("cs_mid_dout", dout, 8'h4B);
    check("cs_mid_usdCs", usdCs, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
